fetch_ctrl: RTL and testbench

Fetch controller that sequences the program-counter register and the instruction-memory port of the multi-cycle RISC-V core. It computes `pc_next` every cycle, issues instruction fetches at the current PC, and buffers the returned word until decode accepts it. It applies branch/jump redirects and traps with defined priority, and reports misaligned redirect targets. It sits between the PC register, instruction memory and the decode stage.

---
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the PC, drives the instruction-memory port and
// buffers one fetched word for decode, with trap/redirect priority handling.
module fetch_ctrl #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   TRAP_VECTOR   = ADDRESS_WIDTH'(32'h0000_0100)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_next,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     trap,
  output logic                     fault_valid,
  output logic [ADDRESS_WIDTH-1:0] fault_addr,
  output logic [31:0]              fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       active;
  logic       trap_take;
  logic       misaligned_take;
  logic       aligned_take;
  logic       flush;
  logic       latch_fetch;

  // Control decode; trap outranks a misaligned redirect, which outranks an aligned one.
  assign active          = (state == REQ) || (state == HOLD);
  assign trap_take       = active && trap;
  assign misaligned_take = active && !trap && redirect_valid && (redirect_target[1:0] != 2'b00);
  assign aligned_take    = active && !trap && redirect_valid && (redirect_target[1:0] == 2'b00);
  assign flush           = trap_take || misaligned_take || aligned_take;
  assign latch_fetch     = (state == REQ) && imem_ack && !flush;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (latch_fetch) begin
          pc_next    = pc + ADDRESS_WIDTH'(4);
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    // Redirects override whatever the state chose.
    if (trap_take || misaligned_take) begin
      pc_next    = TRAP_VECTOR;
      state_next = REQ;
    end else if (aligned_take) begin
      pc_next    = redirect_target;
      state_next = REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= '0;
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_next;
      instr_valid <= (state_next == HOLD);
      if (latch_fetch) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      fault_valid <= misaligned_take;
      if (misaligned_take) fault_addr <= redirect_target;
      // An accept coinciding with a flush still counts.
      if (instr_valid && instr_ready) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC register and a scripted
// instruction memory, and checks against hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  fetch_ctrl #(.ADDRESS_WIDTH(32), .TRAP_VECTOR(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .fault_valid     (fault_valid),
    .fault_addr      (fault_addr),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register surrounding the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else     pc <= pc_next;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    trap = 1'b0;
    cyc();
    cyc();
    settle();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fault_valid", 32'(fault_valid), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // IDLE ignores trap
    trap = 1'b1;
    settle();
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_pc_next", pc_next, 32'd0);
    cyc();
    trap = 1'b0;

    // Zero-wait memory, decode always ready
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      imem_rdata = 32'hA000_0000 + 32'(i);
      instr_ready = 1'b1;
      settle();
      check("zw_req", 32'(imem_req), 32'd1);
      check("zw_addr", imem_addr, 32'(4 * i));
      check("zw_pc_next", pc_next, 32'(4 * i + 4));
      cyc();
      imem_ack = 1'b0;
      settle();
      check("zw_valid", 32'(instr_valid), 32'd1);
      check("zw_instr", instr, 32'hA000_0000 + 32'(i));
      check("zw_instr_pc", instr_pc, 32'(4 * i));
      check("zw_hold_req", 32'(imem_req), 32'd0);
      check("zw_count", fetch_count, 32'(i));
      cyc();
    end
    settle();
    check("zw_count3", fetch_count, 32'd3);
    check("zw_next_addr", imem_addr, 32'h0000_000C);

    // Ack delayed three cycles
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("dly_req", 32'(imem_req), 32'd1);
      check("dly_addr", imem_addr, 32'h0000_000C);
      check("dly_pc_next", pc_next, 32'h0000_000C);
      check("dly_valid", 32'(instr_valid), 32'd0);
      cyc();
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hB000_000B;
    settle();
    check("dly_ack_pc_next", pc_next, 32'h0000_0010);
    cyc();
    imem_ack = 1'b0;
    settle();
    check("dly_valid_after", 32'(instr_valid), 32'd1);

    // HOLD with decode stalled for five cycles
    for (int k = 0; k < 5; k++) begin
      settle();
      check("hold_instr", instr, 32'hB000_000B);
      check("hold_instr_pc", instr_pc, 32'h0000_000C);
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_pc_next", pc_next, 32'h0000_0010);
      cyc();
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    settle();
    check("hold_release_addr", imem_addr, 32'h0000_0010);
    check("hold_release_req", 32'(imem_req), 32'd1);
    check("hold_release_count", fetch_count, 32'd4);

    // Redirect coinciding with ack: data dropped
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0040;
    settle();
    check("redir_pc_next", pc_next, 32'h0000_0040);
    cyc();
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    settle();
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0040);
    cyc();
    settle();
    check("redir_wait_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hC000_00CC;
    cyc();
    imem_ack = 1'b0;
    settle();
    check("redir_fetch_valid", 32'(instr_valid), 32'd1);
    check("redir_fetch_instr", instr, 32'hC000_00CC);
    check("redir_fetch_pc", instr_pc, 32'h0000_0040);

    // Misaligned redirect in HOLD, coinciding with an accept
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0042;
    settle();
    check("mis_pc_next", pc_next, 32'h0000_0100);
    cyc();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    settle();
    check("mis_fault_valid", 32'(fault_valid), 32'd1);
    check("mis_fault_addr", fault_addr, 32'h0000_0042);
    check("mis_addr", imem_addr, 32'h0000_0100);
    check("mis_valid", 32'(instr_valid), 32'd0);
    check("mis_count", fetch_count, 32'd5);
    cyc();
    settle();
    check("mis_pulse_end", 32'(fault_valid), 32'd0);
    check("mis_addr_held", fault_addr, 32'h0000_0042);

    // Trap outranks aligned redirect
    trap = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0080;
    settle();
    check("trap_pc_next", pc_next, 32'h0000_0100);
    cyc();
    settle();
    check("trap_addr", imem_addr, 32'h0000_0100);
    // Trap outranks misaligned redirect: no fault reported
    redirect_target = 32'h0000_0082;
    cyc();
    trap = 1'b0;
    redirect_valid = 1'b0;
    settle();
    check("trap_no_fault", 32'(fault_valid), 32'd0);
    check("trap_fault_addr", fault_addr, 32'h0000_0042);

    // Asynchronous reset in the middle of REQ
    cyc();
    rst = 1'b1;
    #1;
    check("mrst_req", 32'(imem_req), 32'd0);
    check("mrst_count", fetch_count, 32'd0);
    check("mrst_fault_addr", fault_addr, 32'd0);
    check("mrst_instr", instr, 32'd0);
    check("mrst_instr_pc", instr_pc, 32'd0);
    check("mrst_pc_next", pc_next, pc);
    cyc();
    rst = 1'b0;
    cyc();

    // PC increment wraps at the top of the address space
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    settle();
    check("wrap_redir", pc_next, 32'hFFFF_FFFC);
    cyc();
    redirect_valid = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0013;
    settle();
    check("wrap_pc_next", pc_next, 32'd0);
    cyc();
    imem_ack = 1'b0;
    settle();
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
